// File: rtl/pnm_pkg.sv
// Shared types and helpers for the PNM result write-back path.
package pnm_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} wb_state_t;

    function automatic int page_addr_bits(input int num_pages);
        return $clog2(num_pages);
    endfunction

    // Bit 'pos' of a one-hot page strobe selecting page 'sel'.
    function automatic logic onehot_hit(input int sel, input int pos);
        return (sel == pos);
    endfunction

endpackage

// File: rtl/pnm_sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only together with a pop.
module pnm_sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries data only; validity is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pnm_result_writeback.sv
// Buffers engine results and writes them, one per cycle, into page-banked result memory.
module pnm_result_writeback
    import pnm_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int Address_Size = 16,
    parameter int NUM_PAGES    = 64,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          WB_Start,
    input  logic [Address_Size-1:0]                       WB_Count,
    input  logic [DATA_WIDTH-1:0]                         Din,
    input  logic [Address_Size-1:0]                       Din_Addr,
    input  logic                                          Din_Valid,
    output logic                                          Almost_Full,
    output logic                                          Overflow,
    output logic [NUM_PAGES-1:0]                          Mem_Wr_En,
    output logic [Address_Size-page_addr_bits(NUM_PAGES)-1:0] Mem_Wr_Addr,
    output logic [DATA_WIDTH-1:0]                         Mem_Wr_Data,
    input  logic                                          Mem_Wr_Ready,
    output logic                                          done_WB
);

    localparam int PAGE_BITS = page_addr_bits(NUM_PAGES);
    localparam int OFF_BITS  = Address_Size - PAGE_BITS;
    localparam int FW        = Address_Size + DATA_WIDTH;
    localparam int CW        = $clog2(FIFO_DEPTH) + 1;

    wb_state_t                state;
    wb_state_t                state_next;
    logic [Address_Size-1:0]  count_lat;
    logic [Address_Size-1:0]  accepted;
    logic                     overflow_q;
    logic                     done_q;

    logic                     out_vld;
    logic [Address_Size-1:0]  out_addr;
    logic [DATA_WIDTH-1:0]    out_data;
    logic [PAGE_BITS-1:0]     out_page;

    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [FW-1:0]            fifo_rdata;
    logic [CW-1:0]            fifo_count;

    logic                     retire;
    logic                     want;
    logic                     drop;

    assign retire    = out_vld & Mem_Wr_Ready;
    assign fifo_pop  = ~fifo_empty & (~out_vld | retire);
    // Results beyond the programmed count are not part of the job and are ignored.
    assign want      = (state == RUN) & Din_Valid & (accepted < count_lat);
    assign fifo_push = want & (~fifo_full | fifo_pop);
    assign drop      = want & ~fifo_push;

    pnm_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({Din_Addr, Din}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (WB_Start) state_next = RUN;
            RUN:     if (accepted == count_lat) state_next = DRAIN;
            DRAIN:   if (fifo_empty && !out_vld) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control: state, job counters, sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count_lat  <= '0;
            accepted   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b1;
        end else begin
            state  <= state_next;
            // Registered: completion shows the cycle after DONE and drops the cycle after WB_Start.
            done_q <= (state == DONE) | ((state == IDLE) & ~WB_Start);
            if (state == IDLE && WB_Start) begin
                count_lat  <= WB_Count;
                accepted   <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (fifo_push) accepted   <= accepted + 1'b1;
                if (drop)      overflow_q <= 1'b1;
            end
        end
    end

    // Output stage: refilled from the FIFO head whenever empty or retiring
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_addr <= '0;
            out_data <= '0;
        end else if (fifo_pop) begin
            out_vld  <= 1'b1;
            out_addr <= fifo_rdata[FW-1 -: Address_Size];
            out_data <= fifo_rdata[DATA_WIDTH-1:0];
        end else if (retire) begin
            out_vld  <= 1'b0;
        end
    end

    assign out_page = out_addr[Address_Size-1 -: PAGE_BITS];

    always_comb begin
        Mem_Wr_En = '0;
        for (int i = 0; i < NUM_PAGES; i++) begin
            Mem_Wr_En[i] = out_vld & onehot_hit(int'(out_page), i);
        end
    end

    assign Mem_Wr_Addr = out_addr[OFF_BITS-1:0];
    assign Mem_Wr_Data = out_data;
    assign Almost_Full = (fifo_count >= CW'(FIFO_DEPTH - 1));
    assign Overflow    = overflow_q;
    assign done_WB     = done_q;

endmodule

// File: tb/tb_pnm_result_writeback.sv
// Directed + randomized checks of pnm_result_writeback against a queue-based reference model.
module tb_pnm_result_writeback;

    localparam int DW = 32;
    localparam int AS = 16;
    localparam int NP = 64;
    localparam int FD = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          WB_Start;
    logic [AS-1:0] WB_Count;
    logic [DW-1:0] Din;
    logic [AS-1:0] Din_Addr;
    logic          Din_Valid;
    logic          Almost_Full;
    logic          Overflow;
    logic [NP-1:0] Mem_Wr_En;
    logic [9:0]    Mem_Wr_Addr;
    logic [DW-1:0] Mem_Wr_Data;
    logic          Mem_Wr_Ready;
    logic          done_WB;

    always #5 clk = ~clk;

    pnm_result_writeback #(
        .DATA_WIDTH   (DW),
        .Address_Size (AS),
        .NUM_PAGES    (NP),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .WB_Start     (WB_Start),
        .WB_Count     (WB_Count),
        .Din          (Din),
        .Din_Addr     (Din_Addr),
        .Din_Valid    (Din_Valid),
        .Almost_Full  (Almost_Full),
        .Overflow     (Overflow),
        .Mem_Wr_En    (Mem_Wr_En),
        .Mem_Wr_Addr  (Mem_Wr_Addr),
        .Mem_Wr_Data  (Mem_Wr_Data),
        .Mem_Wr_Ready (Mem_Wr_Ready),
        .done_WB      (done_WB)
    );

    // Reference model: every accepted result waits in q until the memory takes it.
    typedef struct {
        logic [AS-1:0] addr;
        logic [DW-1:0] data;
        int            avail;
    } ent_t;

    ent_t q[$];
    int   ph;        // 0 idle, 1 collecting, 2 draining, 3 done
    int   m_cnt;
    int   m_acc;
    bit   m_ovf;
    bit   m_done;
    int   cyc;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   wr_seen = 0;

    always @(negedge clk) begin
        if (Mem_Wr_En != '0 && Mem_Wr_Ready) wr_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ph = 0; m_cnt = 0; m_acc = 0; m_ovf = 0; m_done = 1;
    endtask

    task automatic step();
        bit   pres, ret, acc, drp, ndone;
        int   occ, nph, av;
        ent_t h, e;
        pres = (q.size() > 0) && (q[0].avail <= cyc);
        occ  = q.size() - (pres ? 1 : 0);
        if (pres) begin
            h = q[0];
            chk("wr_en", Mem_Wr_En, 64'd1 << h.addr[15:10]);
            chk("wr_addr", 64'(Mem_Wr_Addr), 64'(h.addr[9:0]));
            chk("wr_data", 64'(Mem_Wr_Data), 64'(h.data));
        end else begin
            chk("wr_en_quiet", Mem_Wr_En, 64'd0);
        end
        chk("done_wb", 64'(done_WB), 64'(m_done));
        chk("overflow", 64'(Overflow), 64'(m_ovf));
        chk("almost_full", 64'(Almost_Full), 64'(occ >= FD - 1));

        ret = pres && Mem_Wr_Ready;
        acc = (ph == 1) && Din_Valid && (m_acc < m_cnt) && ((q.size() < FD + 1) || ret);
        drp = (ph == 1) && Din_Valid && (m_acc < m_cnt) && !acc;
        case (ph)
            0:       nph = WB_Start ? 1 : 0;
            1:       nph = (m_acc == m_cnt) ? 2 : 1;
            2:       nph = (q.size() == 0) ? 3 : 2;
            default: nph = 0;
        endcase
        ndone = (ph == 3) || (ph == 0 && !WB_Start);
        av = cyc + 2;
        e.addr = Din_Addr; e.data = Din; e.avail = av;

        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            if (ret) void'(q.pop_front());
            if (acc) begin q.push_back(e); m_acc++; end
            if (ph == 0 && WB_Start) begin m_cnt = int'(WB_Count); m_acc = 0; m_ovf = 0; end
            if (drp) m_ovf = 1;
            ph = nph;
            m_done = ndone;
        end
    endtask

    task automatic start_job(input int cnt);
        WB_Start = 1'b1; WB_Count = AS'(cnt);
        step();
        WB_Start = 1'b0;
    endtask

    task automatic send(input logic [AS-1:0] a, input logic [DW-1:0] d);
        Din_Valid = 1'b1; Din_Addr = a; Din = d;
        step();
        Din_Valid = 1'b0;
    endtask

    task automatic finish_job(input int max_cycles);
        int n;
        n = 0;
        Din_Valid = 1'b0;
        while (ph != 0 && n < max_cycles) begin
            step();
            n++;
        end
        chk("job_complete", 64'(done_WB), 64'd1);
    endtask

    initial begin
        int base, low;
        logic [DW-1:0] t1_data [4];
        t1_data[0] = 32'hFFFF_FFFB; t1_data[1] = 32'd7; t1_data[2] = 32'd0; t1_data[3] = 32'd9;

        rst = 1'b1; WB_Start = 1'b0; WB_Count = '0; Din = '0; Din_Addr = '0;
        Din_Valid = 1'b0; Mem_Wr_Ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();
        cyc = 0;
        chk("rst_wr_en", Mem_Wr_En, 64'd0);
        chk("rst_wr_addr", 64'(Mem_Wr_Addr), 64'd0);
        chk("rst_wr_data", 64'(Mem_Wr_Data), 64'd0);
        chk("rst_overflow", 64'(Overflow), 64'd0);
        chk("rst_almost_full", 64'(Almost_Full), 64'd0);
        chk("rst_done", 64'(done_WB), 64'd1);
        rst = 1'b0;
        step();

        // Basic job, four results on page 1
        base = wr_seen;
        start_job(4);
        for (int i = 0; i < 4; i++) send(AS'(16'h0400 + i), t1_data[i]);
        chk("t1_third_en", Mem_Wr_En, 64'h2);
        chk("t1_third_addr", 64'(Mem_Wr_Addr), 64'd2);
        chk("t1_third_data", 64'(Mem_Wr_Data), 64'd0);
        finish_job(40);
        chk("t1_writes", 64'(wr_seen - base), 64'd4);

        // Back-pressure: fill FIFO and output register, then overflow
        base = wr_seen;
        Mem_Wr_Ready = 1'b0;
        start_job(16);
        for (int i = 0; i < 10; i++) send(AS'(16'h0800 + i), $urandom);
        chk("t2_overflow", 64'(Overflow), 64'd1);
        chk("t2_almost_full", 64'(Almost_Full), 64'd1);
        Mem_Wr_Ready = 1'b1;
        for (int i = 0; i < 7; i++) send(AS'(16'h0900 + i), $urandom);
        finish_job(60);
        chk("t2_writes", 64'(wr_seen - base), 64'd16);

        // Alternating extreme pages
        start_job(6);
        for (int i = 0; i < 6; i++) send((i % 2 == 0) ? 16'hFC00 : 16'h0000, $urandom);
        finish_job(40);
        chk("t3_overflow_cleared", 64'(Overflow), 64'd0);

        // Empty job
        base = wr_seen;
        start_job(0);
        low = 0;
        for (int i = 0; i < 6; i++) begin
            if (!done_WB) low++;
            step();
        end
        chk("t4_done_low_cycles", 64'(low), 64'd3);
        chk("t4_writes", 64'(wr_seen - base), 64'd0);

        // Reset in the middle of a job with buffered results
        Mem_Wr_Ready = 1'b0;
        start_job(8);
        for (int i = 0; i < 3; i++) send(AS'(16'h1000 + i), $urandom);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_wr_en", Mem_Wr_En, 64'd0);
        chk("t5_done", 64'(done_WB), 64'd1);
        chk("t5_overflow", 64'(Overflow), 64'd0);
        Mem_Wr_Ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Stray valids in IDLE and a second WB_Start during a job
        base = wr_seen;
        for (int i = 0; i < 3; i++) send(AS'(16'h2000 + i), $urandom);
        start_job(3);
        send(16'h2400, $urandom);
        WB_Start = 1'b1; WB_Count = 16'd1;
        send(16'h2401, $urandom);
        WB_Start = 1'b0;
        send(16'h2402, $urandom);
        finish_job(40);
        chk("t6_writes", 64'(wr_seen - base), 64'd3);

        // Randomized jobs with random valid and ready patterns
        for (int j = 0; j < 3; j++) begin
            int cnt, n;
            cnt = $urandom_range(1, 20);
            base = wr_seen;
            start_job(cnt);
            n = 0;
            while (ph != 0 && n < 400) begin
                Din_Valid    = ($urandom_range(0, 1) == 1);
                Din_Addr     = AS'($urandom);
                Din          = $urandom;
                Mem_Wr_Ready = ($urandom_range(0, 3) != 0);
                step();
                n++;
            end
            Din_Valid = 1'b0;
            Mem_Wr_Ready = 1'b1;
            finish_job(40);
            chk("rand_writes", 64'(wr_seen - base), 64'(cnt));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
